// File: rtl/bcd_countdown_timer.sv
// 4-digit BCD countdown timer: preset with inc, run/pause with start/stop,
// alarm on reaching 0000 with auto-return to IDLE after ALARM_TICKS ticks.
module bcd_countdown_timer #(
  parameter logic [15:0] PRESET      = 16'h0030,
  parameter int          INC_DIGIT   = 1,
  parameter int          ALARM_TICKS = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        inc,
  output logic [15:0] count,
  output logic [1:0]  state,
  output logic        busy,
  output logic        alarm
);

  localparam int AW = $clog2(ALARM_TICKS + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_ALARM = 2'b11
  } state_t;

  state_t          r_state, w_state;
  logic [15:0]     r_count, w_count;
  logic [AW-1:0]   r_actr,  w_actr;
  logic            r_busy,  r_alarm;

  // Adds 1 at digit INC_DIGIT with decimal carry; carry out of d3 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (d == INC_DIGIT || (d > INC_DIGIT && carry)) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return carry ? 16'h9999 : r;
  endfunction

  // Only called with v != 0, so the borrow never leaves d3.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (borrow) begin
        if (r[4*d +: 4] == 4'd0) begin
          r[4*d +: 4] = 4'd9;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state = r_state;
    w_count = r_count;
    w_actr  = r_actr;
    case (r_state)
      S_IDLE: begin
        if (stop) begin
          w_count = PRESET;
        end else if (start) begin
          if (r_count != 16'h0000) w_state = S_RUN;
        end else if (inc) begin
          w_count = bcd_inc(r_count);
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state = S_PAUSE;
        end else if (tick) begin
          w_count = bcd_dec(r_count);
          if (r_count == 16'h0001) begin
            w_state = S_ALARM;
            w_actr  = '0;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_state = S_IDLE;
          w_count = PRESET;
        end else if (start) begin
          w_state = S_RUN;
        end
      end
      S_ALARM: begin
        // start or stop acknowledges the alarm ahead of any tick
        if (stop || start) begin
          w_state = S_IDLE;
          w_count = PRESET;
          w_actr  = '0;
        end else if (tick) begin
          if (r_actr == AW'(ALARM_TICKS - 1)) begin
            w_state = S_IDLE;
            w_count = PRESET;
            w_actr  = '0;
          end else begin
            w_actr = r_actr + AW'(1);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= PRESET;
      r_actr  <= '0;
      r_busy  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state;
      r_count <= w_count;
      r_actr  <= w_actr;
      r_busy  <= (w_state == S_RUN);
      r_alarm <= (w_state == S_ALARM);
    end
  end

  assign count = r_count;
  assign state = r_state;
  assign busy  = r_busy;
  assign alarm = r_alarm;

endmodule
